// File: rtl/alu_seq_shifter_pkg.sv
// rtl/alu_seq_shifter_pkg.sv - shared modes, states and helpers for the sequential shifter
package alu_shift_pkg;

    localparam logic [2:0] MODE_SHR  = 3'b000;
    localparam logic [2:0] MODE_SHRA = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_ROR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic mode_is_legal(input logic [2:0] m);
        return m <= MODE_ROL;
    endfunction

    // Per-clock amount never exceeds min(STEP, WIDTH-1), so size it from whichever is smaller.
    function automatic int step_n_w(input int width, input int step);
        return (step >= width) ? $clog2(width) : $clog2(step + 1);
    endfunction

endpackage

// File: rtl/alu_seq_shifter_if.sv
// rtl/alu_seq_shifter_if.sv - start/done request and result bundle for the sequential shifter
interface alu_seq_shifter_if #(
    parameter int WIDTH = 32
) ();
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               start;
    logic [2:0]         mode;
    logic [WIDTH-1:0]   in;
    logic [SHAMT_W-1:0] num_shifts;
    logic [WIDTH-1:0]   out;
    logic               cout;
    logic               busy;
    logic               done;
    logic               illegal;

    modport master (
        output start, mode, in, num_shifts,
        input  out, cout, busy, done, illegal
    );

    modport slave (
        input  start, mode, in, num_shifts,
        output out, cout, busy, done, illegal
    );
endinterface

// File: rtl/alu_seq_shifter_step.sv
// rtl/alu_seq_shifter_step.sv - combinational shift of one data word by n positions in a given mode
module shift_step_unit
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int SW   = $clog2(WIDTH),
    localparam int NW   = step_n_w(WIDTH, STEP)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       md,
    input  logic [NW-1:0]    n,
    output logic [WIDTH-1:0] shifted,
    output logic             bit_out
);
    logic [SW-1:0] n_ext;
    logic [SW-1:0] r_idx;
    logic [SW-1:0] l_idx;

    always_comb begin
        n_ext   = SW'(n);
        r_idx   = n_ext - 1'b1;
        // WIDTH is a power of two, so WIDTH-n wraps to -n in SW bits.
        l_idx   = '0 - n_ext;
        shifted = data;
        bit_out = 1'b0;
        case (md)
            MODE_SHR: begin
                shifted = data >> n;
                bit_out = data[r_idx];
            end
            MODE_SHRA: begin
                shifted = $unsigned($signed(data) >>> n);
                bit_out = data[r_idx];
            end
            MODE_SHL: begin
                shifted = data << n;
                bit_out = data[l_idx];
            end
            MODE_ROR: begin
                shifted = (data >> n) | (data << (WIDTH - int'(n)));
                bit_out = data[r_idx];
            end
            MODE_ROL: begin
                shifted = (data << n) | (data >> (WIDTH - int'(n)));
                bit_out = data[l_idx];
            end
            default: begin
                shifted = data;
                bit_out = 1'b0;
            end
        endcase
        if (n_ext == '0) begin
            bit_out = 1'b0;
        end
    end
endmodule

// File: rtl/alu_seq_shifter.sv
// rtl/alu_seq_shifter.sv - iterative shift/rotate unit, up to STEP positions per clock
module alu_seq_shifter
    import alu_shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int STEP    = 1,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               clr,
    alu_seq_shifter_if.slave   bus
);
    localparam int NW = step_n_w(WIDTH, STEP);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [2:0]         md_q, md_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [SHAMT_W-1:0] step_n;
    logic               cout_int_q, cout_int_d;
    logic               cout_q, cout_d;
    logic               illegal_q, illegal_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   shifted;
    logic               bit_out;

    shift_step_unit #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
        .data    (work_q),
        .md      (md_q),
        .n       (NW'(step_n)),
        .shifted (shifted),
        .bit_out (bit_out)
    );

    always_comb begin
        // A STEP of WIDTH or more always covers the whole remaining amount.
        if (STEP >= WIDTH || rem_q < SHAMT_W'(STEP)) begin
            step_n = rem_q;
        end else begin
            step_n = SHAMT_W'(STEP);
        end
    end

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        md_d       = md_q;
        rem_d      = rem_q;
        cout_int_d = cout_int_q;
        illegal_d  = illegal_q;
        out_d      = out_q;
        cout_d     = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    work_d     = bus.in;
                    md_d       = bus.mode;
                    rem_d      = bus.num_shifts;
                    cout_int_d = 1'b0;
                    illegal_d  = !mode_is_legal(bus.mode);
                    if (bus.num_shifts == '0 || !mode_is_legal(bus.mode)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                work_d     = shifted;
                cout_int_d = bit_out;
                rem_d      = rem_q - step_n;
                if (rem_q == step_n) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
        // Results are published on entry to DONE and then held until the next completion.
        if (state_d == ST_DONE) begin
            out_d  = work_d;
            cout_d = cout_int_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q    <= ST_IDLE;
            work_q     <= '0;
            md_q       <= '0;
            rem_q      <= '0;
            cout_int_q <= 1'b0;
            illegal_q  <= 1'b0;
            out_q      <= '0;
            cout_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            md_q       <= md_d;
            rem_q      <= rem_d;
            cout_int_q <= cout_int_d;
            illegal_q  <= illegal_d;
            out_q      <= out_d;
            cout_q     <= cout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.cout    = cout_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.illegal = illegal_q;
endmodule
